// File: rtl/mult_div_hilo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One result bit per RUN cycle, sign correction in FINISH, MTHI/MTLO written directly in IDLE.
module mult_div_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_execute,
    input  logic [2:0]       op_execute,
    input  logic             flush_execute,
    input  logic [WIDTH-1:0] src_A_ALU_execute,
    input  logic [WIDTH-1:0] src_B_ALU_execute,
    output logic [WIDTH-1:0] HI_output,
    output logic [WIDTH-1:0] LO_output,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_isDiv;
    logic             r_negLo;
    logic             r_negHi;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;

    logic             w_issue;
    logic             w_acceptMd;
    logic             w_acceptMthi;
    logic             w_acceptMtlo;
    logic             w_signedOp;
    logic             w_opIsDiv;
    logic             w_signA;
    logic             w_signB;
    logic             w_bZero;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divTrial;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_lowNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFixed;
    logic [WIDTH-1:0] w_finHi;
    logic [WIDTH-1:0] w_finLo;

    // Issue decode: anything arriving while not idle, or together with a flush, is dropped.
    always_comb begin
        w_issue      = start_execute && !flush_execute && (r_state == S_IDLE);
        w_acceptMd   = w_issue && (op_execute[2] == 1'b0);
        w_acceptMthi = w_issue && (op_execute == OP_MTHI);
        w_acceptMtlo = w_issue && (op_execute == OP_MTLO);
        w_signedOp   = (op_execute == OP_MULT) || (op_execute == OP_DIV);
        w_opIsDiv    = op_execute[1];
        w_signA      = w_signedOp && src_A_ALU_execute[WIDTH-1];
        w_signB      = w_signedOp && src_B_ALU_execute[WIDTH-1];
        w_bZero      = (src_B_ALU_execute == '0);
        w_absA       = w_signA ? -src_A_ALU_execute : src_A_ALU_execute;
        w_absB       = w_signB ? -src_B_ALU_execute : src_B_ALU_execute;
    end

    // Multiply keeps {acc,low} as the shifting product with the multiplier in low;
    // divide keeps the partial remainder in acc and shifts quotient bits into low.
    always_comb begin
        w_mulSum   = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opnd} : '0);
        w_divTrial = {r_acc, r_low[WIDTH-1]} - {1'b0, r_opnd};
        if (!r_isDiv) begin
            w_accNext = w_mulSum[WIDTH:1];
            w_lowNext = {w_mulSum[0], r_low[WIDTH-1:1]};
        end else if (!w_divTrial[WIDTH]) begin
            w_accNext = w_divTrial[WIDTH-1:0];
            w_lowNext = {r_low[WIDTH-2:0], 1'b1};
        end else begin
            w_accNext = {r_acc[WIDTH-2:0], r_low[WIDTH-1]};
            w_lowNext = {r_low[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_prod      = {r_acc, r_low};
        w_prodFixed = r_negLo ? -w_prod : w_prod;
        if (r_isDiv) begin
            w_finHi = r_negHi ? -r_acc : r_acc;
            w_finLo = r_negLo ? -r_low : r_low;
        end else begin
            w_finHi = w_prodFixed[2*WIDTH-1:WIDTH];
            w_finLo = w_prodFixed[WIDTH-1:0];
        end
    end

    // Divide by zero leaves quotient all ones and remainder = |A|; suppressing the
    // quotient negate and restoring the dividend sign yields LO=~0, HI=A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_isDiv <= 1'b0;
            r_negLo <= 1'b0;
            r_negHi <= 1'b0;
            r_acc   <= '0;
            r_low   <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acceptMd) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_isDiv <= w_opIsDiv;
                        r_negLo <= (w_signA ^ w_signB) && !(w_opIsDiv && w_bZero);
                        r_negHi <= w_opIsDiv && w_signA;
                        r_acc   <= '0;
                        r_low   <= w_opIsDiv ? w_absA : w_absB;
                        r_opnd  <= w_opIsDiv ? w_absB : w_absA;
                    end else if (w_acceptMthi) begin
                        r_hi <= src_A_ALU_execute;
                    end else if (w_acceptMtlo) begin
                        r_lo <= src_A_ALU_execute;
                    end
                end
                S_RUN: begin
                    if (flush_execute) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_accNext;
                        r_low <= w_lowNext;
                        if (r_cnt == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush_execute) begin
                        r_hi <= w_finHi;
                        r_lo <= w_finLo;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign HI_output = r_hi;
    assign LO_output = r_lo;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult_div_hilo_unit.sv
// Directed bench for mult_div_hilo_unit: a latency/arithmetic model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_mult_div_hilo_unit;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_BAD   = 3'b110;

   logic             clk;
   logic             rst_n;
   logic             startExecute;
   logic [2:0]       opExecute;
   logic             flushExecute;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic [WIDTH-1:0] hiOut;
   logic [WIDTH-1:0] loOut;
   logic             busyOut;

   int errors = 0;
   int checks = 0;
   bit checkEn = 0;

   logic [WIDTH-1:0] modelHi;
   logic [WIDTH-1:0] modelLo;
   logic             modelBusy;
   int               modelRemain;
   logic [WIDTH-1:0] pendHi;
   logic [WIDTH-1:0] pendLo;

   mult_div_hilo_unit #(.WIDTH(WIDTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_execute     (startExecute),
      .op_execute        (opExecute),
      .flush_execute     (flushExecute),
      .src_A_ALU_execute (srcA),
      .src_B_ALU_execute (srcB),
      .HI_output         (hiOut),
      .LO_output         (loOut),
      .busy              (busyOut)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural result of one mul/div op computed with plain integer arithmetic.
   function automatic logic [2*WIDTH-1:0] opResult(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      longint sp;
      logic [63:0] up;
      int sa;
      int sb;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      sa = a;
      sb = b;
      q = '0;
      r = '0;
      case (op)
         OP_MULT: begin
            sp = longint'(sa) * longint'(sb);
            return sp;
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            return up;
         end
         OP_DIV: begin
            if (b == 0) begin
               q = '1;
               r = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               q = 32'h8000_0000;
               r = '0;
            end else begin
               q = sa / sb;
               r = sa % sb;
            end
            return {r, q};
         end
         default: begin
            if (b == 0) begin
               q = '1;
               r = a;
            end else begin
               q = a / b;
               r = a % b;
            end
            return {r, q};
         end
      endcase
   endfunction

   // Reference model: an accepted mul/div lands its result 33 edges later unless flushed.
   always @(posedge clk or negedge rst_n) begin
      logic [2*WIDTH-1:0] res;
      if (!rst_n) begin
         modelHi = '0;
         modelLo = '0;
         modelBusy = 1'b0;
         modelRemain = 0;
      end else if (modelBusy) begin
         if (flushExecute) begin
            modelBusy = 1'b0;
         end else if (modelRemain == 1) begin
            modelHi = pendHi;
            modelLo = pendLo;
            modelBusy = 1'b0;
         end else begin
            modelRemain--;
         end
      end else if (startExecute && !flushExecute) begin
         if (opExecute[2] == 1'b0) begin
            res = opResult(opExecute, srcA, srcB);
            pendHi = res[2*WIDTH-1:WIDTH];
            pendLo = res[WIDTH-1:0];
            modelBusy = 1'b1;
            modelRemain = WIDTH + 1;
         end else if (opExecute == OP_MTHI) begin
            modelHi = srcA;
         end else if (opExecute == OP_MTLO) begin
            modelLo = srcA;
         end
      end
   end

   // Compare DUT against the model on every falling edge once out of reset.
   always @(negedge clk) begin
      if (checkEn && rst_n) begin
         checks++;
         if (busyOut !== modelBusy || hiOut !== modelHi || loOut !== modelLo) begin
            errors++;
            $display("[TB] FAIL model-compare t=%0t: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h",
                     $time, busyOut, hiOut, loOut, modelBusy, modelHi, modelLo);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] expHi,
                              input logic [WIDTH-1:0] expLo, input logic expBusy);
      checks++;
      if (hiOut !== expHi || loOut !== expLo || busyOut !== expBusy) begin
         errors++;
         $display("[TB] FAIL %s: got hi=%h lo=%h busy=%b, expected hi=%h lo=%h busy=%b",
                  name, hiOut, loOut, busyOut, expHi, expLo, expBusy);
      end
   endtask

   task automatic checkBusy(input string name, input logic expBusy);
      checks++;
      if (busyOut !== expBusy) begin
         errors++;
         $display("[TB] FAIL %s: got busy=%b, expected busy=%b", name, busyOut, expBusy);
      end
   endtask

   // Called on a falling edge: presents one op for a single cycle, returns one falling edge later.
   task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic flush);
      startExecute = 1'b1;
      opExecute = op;
      srcA = a;
      srcB = b;
      flushExecute = flush;
      @(negedge clk);
      startExecute = 1'b0;
      flushExecute = 1'b0;
      opExecute = OP_BAD;
   endtask

   // Full mul/div transaction: busy through the last cycle, result visible the cycle after.
   task automatic runOp(input string name, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expHi,
                        input logic [WIDTH-1:0] expLo);
      applyStimulus(op, a, b, 1'b0);
      checkBusy({name, " busy-first"}, 1'b1);
      repeat (32) @(negedge clk);
      checkBusy({name, " busy-last"}, 1'b1);
      @(negedge clk);
      checkOutput(name, expHi, expLo, 1'b0);
   endtask

   // Directed scenario sequence.
   initial begin
      rst_n = 1'b0;
      startExecute = 1'b0;
      opExecute = OP_BAD;
      flushExecute = 1'b0;
      srcA = '0;
      srcB = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset", 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      checkEn = 1;

      runOp("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      runOp("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      runOp("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      runOp("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      runOp("divu by zero", OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
      runOp("div neg by zero", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      applyStimulus(OP_MTHI, 32'hAAAA_0000, 32'h0, 1'b0);
      checkOutput("mthi idle", 32'hAAAA_0000, 32'hFFFF_FFFF, 1'b0);
      applyStimulus(OP_MTLO, 32'h1234_5678, 32'h0, 1'b0);
      checkOutput("mtlo idle", 32'hAAAA_0000, 32'h1234_5678, 1'b0);

      applyStimulus(OP_BAD, 32'hDEAD_BEEF, 32'h1, 1'b0);
      checkOutput("invalid op", 32'hAAAA_0000, 32'h1234_5678, 1'b0);
      applyStimulus(OP_MULT, 32'd3, 32'd3, 1'b1);
      checkOutput("start with flush", 32'hAAAA_0000, 32'h1234_5678, 1'b0);

      // MTLO arriving at busy cycle 5 must be dropped.
      applyStimulus(OP_DIVU, 32'd50, 32'd5, 1'b0);
      repeat (4) @(negedge clk);
      applyStimulus(OP_MTLO, 32'h0000_0055, 32'h0, 1'b0);
      checkOutput("mtlo while busy", 32'hAAAA_0000, 32'h1234_5678, 1'b1);
      repeat (28) @(negedge clk);
      checkOutput("divu after mtlo", 32'h0, 32'd10, 1'b0);

      // Flush at RUN cycle 10.
      applyStimulus(OP_MULT, 32'd7, 32'd9, 1'b0);
      repeat (9) @(negedge clk);
      flushExecute = 1'b1;
      @(negedge clk);
      flushExecute = 1'b0;
      checkOutput("flush in run", 32'h0, 32'd10, 1'b0);
      repeat (30) @(negedge clk);
      checkOutput("flush no late write", 32'h0, 32'd10, 1'b0);

      // Flush on the FINISH cycle suppresses the write.
      applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b0);
      repeat (32) @(negedge clk);
      flushExecute = 1'b1;
      @(negedge clk);
      flushExecute = 1'b0;
      checkOutput("flush in finish", 32'h0, 32'd10, 1'b0);

      runOp("multu 6*7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

      // Asynchronous reset pulse mid-divide.
      applyStimulus(OP_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("reset mid-div", 32'h0, 32'h0, 1'b0);
      #2;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("after reset idle", 32'h0, 32'h0, 1'b0);

      checkEn = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends even if the scenario sequence stalls.
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
